// File: rtl/logic_ctrl_pkg.sv
// Shared definitions for the logical-unit issue controller: opcode set,
// precision encoding and the layout of the microinstruction word.
package logic_ctrl_pkg;
   localparam int DATA_W = 128;
   localparam int OP_W   = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 4'h0, OP_OR   = 4'h1, OP_XOR  = 4'h2, OP_NAND = 4'h3,
      OP_NOR  = 4'h4, OP_XNOR = 4'h5, OP_ANDN = 4'h6, OP_ORN  = 4'h7,
      OP_NOT  = 4'h8, OP_PS0  = 4'h9, OP_PS1  = 4'hA, OP_ZERO = 4'hB,
      OP_ONES = 4'hC, OP_SEL  = 4'hD, OP_MAJ  = 4'hE, OP_NOP  = 4'hF
   } logic_op_e;

   localparam logic PREC_16X8 = 1'b0;
   localparam logic PREC_32X4 = 1'b1;

   localparam int CRU_W      = 6;
   localparam int CRU_VALID  = 5;
   localparam int CRU_OP_MSB = 4;
   localparam int CRU_OP_LSB = 1;
   localparam int CRU_PREC   = 0;

   function automatic logic [CRU_W-1:0] cru_pack(input logic v, input logic [OP_W-1:0] op,
                                                 input logic prec);
      logic [CRU_W-1:0] w;
      w = '0;
      w[CRU_VALID] = v;
      w[CRU_OP_MSB:CRU_OP_LSB] = op;
      w[CRU_PREC] = prec;
      return w;
   endfunction
endpackage

// File: rtl/logic_rr_arb.sv
// Round-robin arbiter with grant lock: a locked owner keeps the grant while
// it stays valid; the pointer only moves on an unlocked issue.
module logic_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] lock,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] owner;
   logic            locked;
   logic            found;
   int              j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      if (locked && req[owner]) begin
         grant[owner] = 1'b1;
         idx          = owner;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               idx      = ID_W'(j);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         owner  <= '0;
         locked <= 1'b0;
      end else if (advance) begin
         if (lock[idx]) begin
            locked <= 1'b1;
            owner  <= idx;
         end else begin
            locked <= 1'b0;
            ptr    <= (idx == ID_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
         end
      end else if (locked && !req[owner]) begin
         locked <= 1'b0;
      end
   end
endmodule

// File: rtl/logic_issue_ctrl.sv
// Issues one requester's logical operation per cycle to the logical unit and
// returns the unit's registered result with the issuing requester's id.
module logic_issue_ctrl
   import logic_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*4-1:0]    req_op,
   input  logic [NUM_REQ-1:0]      req_prec,
   input  logic [NUM_REQ-1:0]      req_lock,
   input  logic [NUM_REQ*128-1:0]  req_s0,
   input  logic [NUM_REQ*128-1:0]  req_s1,
   input  logic [NUM_REQ*128-1:0]  req_st,
   output logic [5:0]              cru_logic,
   output logic [127:0]            dvr_logic_s0,
   output logic [127:0]            dvr_logic_s1,
   output logic [127:0]            dvr_logic_st,
   input  logic [127:0]            dr_logic_d,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [127:0]            rsp_data,
   output logic [NUM_REQ*16-1:0]   issue_cnt
);
   logic [OP_W-1:0]   op_a [NUM_REQ];
   logic [DATA_W-1:0] s0_a [NUM_REQ];
   logic [DATA_W-1:0] s1_a [NUM_REQ];
   logic [DATA_W-1:0] st_a [NUM_REQ];
   logic [15:0]       cnt  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_a[i] = req_op[i*OP_W +: OP_W];
      assign s0_a[i] = req_s0[i*DATA_W +: DATA_W];
      assign s1_a[i] = req_s1[i*DATA_W +: DATA_W];
      assign st_a[i] = req_st[i*DATA_W +: DATA_W];
      assign issue_cnt[i*16 +: 16] = cnt[i];
   end

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    idx;
   logic               vld_q;
   logic               can_issue;
   logic               issue;

   // Reset also blocks issue so nothing reaches the unit while it is held in reset.
   assign can_issue = (!vld_q || rsp_ready) && !rst;
   assign req_ready = grant & {NUM_REQ{can_issue}};
   assign issue     = |req_ready;

   logic_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .lock    (req_lock),
      .advance (issue),
      .grant   (grant),
      .idx     (idx)
   );

   assign cru_logic    = issue ? cru_pack(1'b1, op_a[idx], req_prec[idx]) : '0;
   assign dvr_logic_s0 = issue ? s0_a[idx] : '0;
   assign dvr_logic_s1 = issue ? s1_a[idx] : '0;
   assign dvr_logic_st = issue ? st_a[idx] : '0;

   // Masking with rst drops an in-flight response in the very cycle reset arrives.
   assign rsp_valid = vld_q && !rst;
   assign rsp_data  = dr_logic_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         rsp_id <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         if (issue) begin
            vld_q  <= 1'b1;
            rsp_id <= idx;
         end else if (rsp_ready) begin
            vld_q  <= 1'b0;
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
   end
endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Randomized and directed bench for logic_issue_ctrl against a reference model
// of the arbitration, response and counter rules, with a stub logical unit.
module tb_logic_issue_ctrl;
   localparam int N = 4;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     b_valid, b_prec, b_lock;
   logic [3:0]       b_op [N];
   logic [127:0]     b_s0 [N], b_s1 [N], b_st [N];
   logic [N*4-1:0]   req_op;
   logic [N*128-1:0] req_s0, req_s1, req_st;
   logic [N-1:0]     req_ready;
   logic [5:0]       cru_logic;
   logic [127:0]     dvr_logic_s0, dvr_logic_s1, dvr_logic_st, dr_logic_d, rsp_data;
   logic             rsp_valid, rsp_ready;
   logic [IW-1:0]    rsp_id;
   logic [N*16-1:0]  issue_cnt;

   int nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_op[i*4 +: 4]     = b_op[i];
      assign req_s0[i*128 +: 128] = b_s0[i];
      assign req_s1[i*128 +: 128] = b_s1[i];
      assign req_st[i*128 +: 128] = b_st[i];
   end

   logic_issue_ctrl #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(req_ready),
      .req_op(req_op), .req_prec(b_prec), .req_lock(b_lock),
      .req_s0(req_s0), .req_s1(req_s1), .req_st(req_st),
      .cru_logic(cru_logic), .dvr_logic_s0(dvr_logic_s0), .dvr_logic_s1(dvr_logic_s1),
      .dvr_logic_st(dvr_logic_st), .dr_logic_d(dr_logic_d),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .issue_cnt(issue_cnt)
   );

   function automatic logic [127:0] opf(input logic [3:0] op, input logic [127:0] a,
                                        input logic [127:0] b, input logic [127:0] s);
      case (op)
         4'h0: return a & b;        4'h1: return a | b;
         4'h2: return a ^ b;        4'h3: return ~(a & b);
         4'h4: return ~(a | b);     4'h5: return ~(a ^ b);
         4'h6: return a & ~b;       4'h7: return a | ~b;
         4'h8: return ~a;           4'h9: return a;
         4'hA: return b;            4'hB: return '0;
         4'hC: return '1;           4'hD: return (s & a) | (~s & b);
         4'hE: return (a & b) | (a & s) | (b & s);
         default: return a ^ s;
      endcase
   endfunction

   // Stub logical unit: registered result, reset by ~rst, holds when idle.
   logic unit_rst_n;
   assign unit_rst_n = ~rst;
   always @(posedge clk) begin
      if (!unit_rst_n) dr_logic_d <= '0;
      else if (cru_logic[5]) dr_logic_d <= opf(cru_logic[4:1], dvr_logic_s0, dvr_logic_s1, dvr_logic_st);
   end

   // Reference model state
   int           m_ptr, m_owner, m_id;
   bit           m_locked, m_valid;
   logic [127:0] m_data;
   logic [15:0]  m_cnt [N];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_id = 0; m_locked = 0; m_valid = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
   endtask

   function automatic int mgrant();
      if (rst || (m_valid && !rsp_ready)) return -1;
      if (m_locked && b_valid[m_owner]) return m_owner;
      for (int k = 0; k < N; k++)
         if (b_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic cyc();
      int g;
      logic [N-1:0]    erdy;
      logic [5:0]      ecru;
      logic [N*16-1:0] ecnt;
      #1;
      g = mgrant();
      erdy = '0; ecru = '0;
      if (g >= 0) begin
         erdy[g] = 1'b1;
         ecru = {1'b1, b_op[g], b_prec[g]};
      end
      for (int i = 0; i < N; i++) ecnt[i*16 +: 16] = m_cnt[i];
      check("req_ready", 128'(req_ready), 128'(erdy));
      check("cru_logic", 128'(cru_logic), 128'(ecru));
      check("dvr_s0", dvr_logic_s0, (g >= 0) ? b_s0[g] : 128'h0);
      check("dvr_s1", dvr_logic_s1, (g >= 0) ? b_s1[g] : 128'h0);
      check("dvr_st", dvr_logic_st, (g >= 0) ? b_st[g] : 128'h0);
      check("rsp_valid", 128'(rsp_valid), 128'(m_valid && !rst));
      check("rsp_id", 128'(rsp_id), 128'(m_id));
      if (m_valid && !rst) check("rsp_data", rsp_data, m_data);
      check("issue_cnt", 128'(issue_cnt), 128'(ecnt));
      @(posedge clk);
      if (rst) model_reset();
      else if (g >= 0) begin
         if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
         m_data  = opf(b_op[g], b_s0[g], b_s1[g], b_st[g]);
         m_id    = g;
         m_valid = 1;
         if (b_lock[g]) begin m_locked = 1; m_owner = g; end
         else begin m_locked = 0; m_ptr = (g + 1) % N; end
      end else begin
         if (rsp_ready) m_valid = 0;
         if (m_locked && !b_valid[m_owner]) m_locked = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      b_valid = '0; b_prec = '0; b_lock = '0; rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         b_op[i] = '0; b_s0[i] = '0; b_s1[i] = '0; b_st[i] = '0;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [127:0] hold_data;

   initial begin
      idle_inputs();
      rst = 1'b1;
      b_valid = 4'hF;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      // Reset with every requester valid
      #1;
      check("rst_ready", 128'(req_ready), 128'h0);
      check("rst_cru", 128'(cru_logic), 128'h0);
      check("rst_cnt", 128'(issue_cnt), 128'h0);
      cyc();
      rst = 1'b0;
      #1 check("first_grant", 128'(req_ready), 128'h1);
      cyc();

      // Datapath: AND at 32-bit precision from requester 0
      b_valid = 4'b0001; b_op[0] = 4'h0; b_prec[0] = 1'b1;
      b_s0[0] = {4{32'hFFFF0000}}; b_s1[0] = {4{32'h0F0F0F0F}}; b_st[0] = rnd128();
      #1 check("dp_cru", 128'(cru_logic), 128'(6'b100001));
      cyc();
      b_valid = '0;
      #1;
      check("dp_data", rsp_data, {4{32'h0F0F0000}});
      check("dp_id", 128'(rsp_id), 128'h0);
      cyc();

      // Round-robin with continuous drain
      do_reset(1);
      b_valid = 4'hF; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 check("rr_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
         if (k > 0) begin
            check("rr_rsp_valid", 128'(rsp_valid), 128'h1);
            check("rr_rsp_id", 128'(rsp_id), 128'((k - 1) % 4));
         end
         cyc();
      end

      // Backpressure: ptr is at 1 here
      cyc();
      rsp_ready = 1'b0;
      #1 hold_data = rsp_data;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready", 128'(req_ready), 128'h0);
         check("bp_id", 128'(rsp_id), 128'h1);
         check("bp_data", rsp_data, hold_data);
         cyc();
      end
      rsp_ready = 1'b1;
      #1 check("bp_release", 128'(req_ready), 128'(4'b0100));
      cyc();

      // Lock: requester 1 held for three grants
      do_reset(1);
      b_valid = 4'hF;
      cyc();
      b_lock[1] = 1'b1;
      #1 check("lk_g1", 128'(req_ready), 128'(4'b0010));
      cyc();
      #1 check("lk_g2", 128'(req_ready), 128'(4'b0010));
      cyc();
      b_lock[1] = 1'b0;
      #1 check("lk_g3", 128'(req_ready), 128'(4'b0010));
      cyc();
      #1 check("lk_next", 128'(req_ready), 128'(4'b0100));
      cyc();

      // Counter saturation on requester 3
      do_reset(1);
      b_valid = 4'b1000;
      repeat (65535) cyc();
      #1 check("sat_full", 128'(issue_cnt[63:48]), 128'(16'hFFFF));
      cyc();
      #1 check("sat_hold", 128'(issue_cnt[63:48]), 128'(16'hFFFF));
      // Reset right after an issue swallows the response
      rst = 1'b1;
      #1 check("midrst_vld", 128'(rsp_valid), 128'h0);
      cyc();
      rst = 1'b0; b_valid = '0;
      #1 check("midrst_after", 128'(rsp_valid), 128'h0);
      cyc();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         b_valid = N'($urandom);
         b_lock = N'($urandom) & N'($urandom);
         b_prec = N'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            b_op[i] = 4'($urandom);
            b_s0[i] = rnd128(); b_s1[i] = rnd128(); b_st[i] = rnd128();
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/logic_issue_ctrl.md
LOGIC_ISSUE_CTRL -- requirements
Module: logic_issue_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter ID_W, default $clog2(NUM_REQ), giving the requester-id width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  in  1  sole clock, rising edge.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 Port req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 Port req_op  in  NUM_REQ*4  per-requester logical opcode, encoded as in logic_ctrl_pkg.
REQ-009 Port req_prec  in  NUM_REQ  per-requester precision: 1 = 32-bit x4, 0 = 16-bit x8.
REQ-010 Port req_lock  in  NUM_REQ  per-requester request to keep the grant for its next operation.
REQ-011 Port req_s0 / req_s1 / req_st  in  NUM_REQ*128 each  per-requester source 0, source 1 and status operands.
REQ-012 Port cru_logic  out  6  microinstruction to the logical unit: bit 5 = valid, bits 4:1 = op, bit 0 = precision.
REQ-013 Port dvr_logic_s0 / dvr_logic_s1 / dvr_logic_st  out  128 each  operands to the logical unit.
REQ-014 Port dr_logic_d  in  128  logical unit result, registered inside the unit.
REQ-015 Port rsp_valid  out  1  response valid.
REQ-016 Port rsp_ready  in  1  response accept from the consumer.
REQ-017 Port rsp_id  out  ID_W  index of the requester that issued the operation.
REQ-018 Port rsp_data  out  128  operation result.
REQ-019 Port issue_cnt  out  NUM_REQ*16  per-requester issued-operation counters.

Function
REQ-020 can_issue SHALL be high when rsp_valid is 0 or rsp_ready is 1.
REQ-021 Grant selection SHALL be round-robin: the valid requester with the lowest index at or above ptr wins, wrapping to 0; ptr SHALL update to (g+1) mod NUM_REQ after an issue from requester g.
REQ-022 req_ready SHALL be one-hot or zero: req_ready[g] = can_issue AND the grant to g; this path is combinational from req_valid.
REQ-023 In an issue cycle, cru_logic SHALL be {1, req_op[g], req_prec[g]}, and dvr_logic_* SHALL equal requester g's operands.
REQ-024 In a non-issue cycle, cru_logic[5] SHALL be 0 and dvr_logic_* SHALL be 0.
REQ-025 Lock: if g issues with req_lock[g]=1, only g SHALL be grantable until g issues with req_lock[g]=0 or drops req_valid[g]; ptr SHALL not advance while the lock is held.
REQ-026 Response timing: rsp_valid SHALL be 1 in the cycle after an issue; rsp_id SHALL be the registered g; rsp_data SHALL pass dr_logic_d through combinationally (latency 1).
REQ-027 Simultaneous rsp_ready=1 and a new issue SHALL keep rsp_valid at 1 with the new id, giving throughput of 1 op/cycle.
REQ-028 rsp_ready=0 while rsp_valid=1 SHALL block all issue, so dr_logic_d holds and rsp_data and rsp_id stay stable.
REQ-029 rsp_valid SHALL clear when rsp_ready=1 and there is no issue.
REQ-030 issue_cnt[g] SHALL increment on each issue by g and saturate at 0xFFFF.
REQ-031 Opcodes SHALL be forwarded unchecked; all 16 encodings are legal.

Reset
REQ-032 While rst=1, at the next edge: rsp_valid=0, rsp_id=0, ptr=0, lock cleared, all issue_cnt=0.
REQ-033 While rst=1, req_ready and cru_logic SHALL be 0 and dvr_logic_* SHALL be 0.
REQ-034 Reset mid-operation SHALL discard any in-flight response with no rsp_valid pulse.
REQ-035 At integration, the logical unit reset SHALL be driven as rst_n = ~rst.

Structure
REQ-036 logic_ctrl_pkg SHALL hold the 16 opcode constants, the precision encoding, CRU field positions and DATA_W=128.
REQ-037 The round-robin-with-lock selection SHALL be one sub-module, logic_rr_arb (inputs req, lock, advance; outputs one-hot grant and index).

Verification
REQ-038 Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0, cru_logic=0, issue_cnt=0; first grant after release goes to requester 0.
REQ-039 Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id follows one cycle later; rsp_valid stays 1 continuously.
REQ-040 Datapath: req0 op AND, prec=1, s0=0xFFFF0000 per lane, s1=0x0F0F0F0F -> cru_logic=6'b100001; next cycle rsp_data=0x0F0F0000 x4, rsp_id=0.
REQ-041 Backpressure: rsp_ready=0 for 3 cycles after an issue -> no further issue; rsp_data and rsp_id stable; rsp_ready=1 releases the next issue in the same cycle.
REQ-042 Lock: req1 issues with req_lock=1 twice while req_valid=4'b1111 -> requester 1 is granted 3 consecutive times (the last with lock=0); then requester 2 is granted.
REQ-043 Saturation and mid-op reset: preload 65535 issues on req3 -> issue_cnt[3]=0xFFFF and stays there; rst asserted on the cycle after an issue -> no rsp_valid observed.
